// File: rtl/commit_trace_mon.sv
// commit_trace_mon: classifies retired instructions into numbered trace
// records, buffers them in a show-ahead FIFO drained over valid/ready,
// and signals done once the HALT record has been consumed.
module commit_trace_mon #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       commit_valid,
    input  logic [DATA_W-1:0]          commit_pc,
    input  logic [DATA_W-1:0]          commit_inst,
    input  logic                       reg_write,
    input  logic [REG_W-1:0]           write_reg,
    input  logic [DATA_W-1:0]          write_data,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [DATA_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_data,
    input  logic                       halt,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [2:0]                 rec_kind,
    output logic [31:0]                rec_inum,
    output logic [DATA_W-1:0]          rec_pc,
    output logic [DATA_W-1:0]          rec_val,
    output logic [DATA_W-1:0]          rec_addr,
    output logic [DATA_W-1:0]          rec_mval,
    output logic [REG_W-1:0]           rec_reg,
    output logic [31:0]                inst_count,
    output logic [31:0]                cycle_count,
    output logic [15:0]                drop_count,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [2:0] KIND_NOP  = 3'd0;
    localparam logic [2:0] KIND_REG  = 3'd1;
    localparam logic [2:0] KIND_LD   = 3'd2;
    localparam logic [2:0] KIND_ST   = 3'd3;
    localparam logic [2:0] KIND_STU  = 3'd4;
    localparam logic [2:0] KIND_HALT = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]        kind;
        logic [31:0]       inum;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] mval;
        logic [REG_W-1:0]  rreg;
    } rec_t;

    state_t             state_reg, state_next;
    rec_t               mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]   level_reg;
    logic [31:0]        inst_count_reg;
    logic [31:0]        cycle_count_reg;
    logic [15:0]        drop_count_reg;
    logic               hold_valid_reg;
    rec_t               hold_rec_reg;

    rec_t               new_rec;
    rec_t               push_rec;
    rec_t               head_rec;
    logic               accept;
    logic               pop;
    logic               full;
    logic               slot_free;
    logic               push;
    logic               hold_set;
    logic               hold_clr;
    logic               drop;

    // The instruction word is not part of any record.
    logic               unused_inst;
    assign unused_inst = ^commit_inst;

    assign full      = (level_reg == LVL_W'(DEPTH));
    assign rec_valid = (level_reg != '0);
    assign pop       = rec_valid && rec_ready;
    assign slot_free = !full || pop;
    assign accept    = commit_valid && (state_reg == ST_RUN);
    assign head_rec  = mem[rd_ptr_reg];

    // Classify the retiring instruction; fields a kind does not use stay 0.
    always_comb begin
        new_rec      = '0;
        new_rec.inum = inst_count_reg;
        new_rec.pc   = commit_pc;
        if (reg_write && mem_write) begin
            new_rec.kind = KIND_STU;
            new_rec.rreg = write_reg;
            new_rec.val  = write_data;
            new_rec.addr = mem_addr;
            new_rec.mval = mem_data;
        end else if (reg_write && mem_read) begin
            new_rec.kind = KIND_LD;
            new_rec.rreg = write_reg;
            new_rec.val  = write_data;
            new_rec.addr = mem_addr;
        end else if (reg_write) begin
            new_rec.kind = KIND_REG;
            new_rec.rreg = write_reg;
            new_rec.val  = write_data;
        end else if (halt) begin
            new_rec.kind = KIND_HALT;
        end else if (mem_write) begin
            new_rec.kind = KIND_ST;
            new_rec.addr = mem_addr;
            new_rec.mval = mem_data;
        end else begin
            new_rec.kind = KIND_NOP;
        end
    end

    // Next-state and push/hold/drop decisions. Only one push source is
    // active per state, so the FIFO write port is never contended.
    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        push_rec   = new_rec;
        hold_set   = 1'b0;
        hold_clr   = 1'b0;
        drop       = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (accept) begin
                    if (slot_free) begin
                        push = 1'b1;
                        if (new_rec.kind == KIND_HALT) begin
                            state_next = ST_DRAIN;
                        end
                    end else if (new_rec.kind == KIND_HALT) begin
                        hold_set   = 1'b1;
                        state_next = ST_HALT_PEND;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_HALT_PEND: begin
                if (hold_valid_reg && slot_free) begin
                    push       = 1'b1;
                    push_rec   = hold_rec_reg;
                    hold_clr   = 1'b1;
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish on the edge that consumes the last record.
                if (level_reg == '0 || (level_reg == LVL_W'(1) && pop)) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_DONE;
            end
        endcase
    end

    // Record storage; no reset needed because outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_rec;
        end
    end

    // State, pointers, occupancy, counters and the HALT holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_RUN;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            level_reg       <= '0;
            inst_count_reg  <= '0;
            cycle_count_reg <= '0;
            drop_count_reg  <= '0;
            hold_valid_reg  <= 1'b0;
            hold_rec_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                level_reg <= level_reg + LVL_W'(1);
            end else if (pop && !push) begin
                level_reg <= level_reg - LVL_W'(1);
            end
            if (accept) begin
                inst_count_reg <= inst_count_reg + 32'd1;
            end
            if (state_reg != ST_DONE) begin
                cycle_count_reg <= cycle_count_reg + 32'd1;
            end
            if (drop && drop_count_reg != 16'hFFFF) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end
            if (hold_set) begin
                hold_valid_reg <= 1'b1;
                hold_rec_reg   <= new_rec;
            end else if (hold_clr) begin
                hold_valid_reg <= 1'b0;
            end
        end
    end

    assign rec_kind    = rec_valid ? head_rec.kind : '0;
    assign rec_inum    = rec_valid ? head_rec.inum : '0;
    assign rec_pc      = rec_valid ? head_rec.pc   : '0;
    assign rec_val     = rec_valid ? head_rec.val  : '0;
    assign rec_addr    = rec_valid ? head_rec.addr : '0;
    assign rec_mval    = rec_valid ? head_rec.mval : '0;
    assign rec_reg     = rec_valid ? head_rec.rreg : '0;
    assign inst_count  = inst_count_reg;
    assign cycle_count = cycle_count_reg;
    assign drop_count  = drop_count_reg;
    assign fifo_level  = level_reg;
    assign done        = (state_reg == ST_DONE);

endmodule

// File: doc/commit_trace_mon.md
# commit_trace_mon

Synthesizable commit-trace monitor for the pipelined processor, successor to the single-cycle bench trace logic. It classifies every retired instruction from the writeback stage into a trace record (NOP/branch, REG, LD, ST, STU, HALT), numbers it, and buffers it in a parametrised FIFO. A consumer (bench writer or debug port) drains the FIFO over a valid/ready handshake. On halt the monitor stops accepting commits, drains, and asserts `done`.

## Interface
- `DATA_W`, 16, width of PC, instruction, register data, memory address and memory data
- `REG_W`, 3, register-select width
- `DEPTH`, 8, FIFO entries; power of two, at least 2
- `clk` in 1: the single clock
- `rst` in 1: synchronous, active-high reset
- `commit_valid` in 1: a real instruction retires this cycle; bubbles have this low
- `commit_pc`, `commit_inst` in DATA_W: PC and instruction of the retiring instruction
- `reg_write` in 1, `write_reg` in REG_W, `write_data` in DATA_W: register writeback
- `mem_read`, `mem_write` in 1; `mem_addr`, `mem_data` in DATA_W: memory access of the retiring instruction
- `halt` in 1: the retiring instruction is HALT
- `rec_valid` out 1, `rec_ready` in 1: output handshake
- `rec_kind` out 3: 0 NOP, 1 REG, 2 LD, 3 ST, 4 STU, 5 HALT
- `rec_inum` out 32; `rec_pc`, `rec_val`, `rec_addr`, `rec_mval` out DATA_W; `rec_reg` out REG_W: record fields
- `inst_count`, `cycle_count` out 32: retired instructions and elapsed cycles
- `drop_count` out 16: records lost to overflow
- `fifo_level` out log2(DEPTH)+1: current occupancy
- `done` out 1: halt record consumed and FIFO empty

## Operation
- Classification, applied only when `commit_valid` is high and the state is RUN, in priority order:
  - `reg_write & mem_write` gives STU.
  - `reg_write & mem_read` gives LD.
  - `reg_write` gives REG.
  - `halt` gives HALT.
  - `mem_write` gives ST.
  - Otherwise NOP.
- Record fields:
  - `rec_inum` is `inst_count` before the increment.
  - `rec_val` is `write_data`; `rec_addr` is `mem_addr`; `rec_mval` is `mem_data`.
  - Unused fields are stored as 0.
- `inst_count` increments on every accepted commit, including dropped records. It wraps at 2^32.
- `cycle_count` increments every cycle in every state except DONE.
- FIFO: show-ahead; `rec_valid` = not empty; a pop occurs on `rec_valid & rec_ready`.
- When full with no pop in the same cycle, a non-HALT record is dropped and `drop_count` increments, saturating at 0xFFFF. A push is accepted when full if a pop occurs in the same cycle.
- A HALT record is never dropped. If the FIFO is full, the HALT record goes into a one-entry holding register and is pushed on the first cycle a slot frees.
- State machine:
  - RUN goes to DRAIN when the HALT record is pushed, or to HALT_PEND when it is held.
  - HALT_PEND goes to DRAIN when the held record is pushed.
  - DRAIN goes to DONE when the FIFO is empty.
  - DONE is absorbing until `rst`.
- In HALT_PEND, DRAIN and DONE, all commits are ignored: no record, no count.
- `done` = (state == DONE).

## Timing
- Reset values:
  - All counters 0.
  - FIFO empty; `rec_valid` 0; `fifo_level` 0.
  - `done` 0; state RUN; holding register invalid.
  - Record outputs 0.
- `rst` mid-operation discards all buffered and held records on the next edge.
- Commit at edge N makes `rec_valid` high after edge N, so the record is visible in cycle N+1 if the FIFO was empty. Latency is 1 cycle.
- `inst_count` and `fifo_level` update at the same edge as the push.
- Record outputs are stable while `rec_valid & !rec_ready`.
- `rec_valid` must not drop without a pop.
- A pop of the last entry in DRAIN leads to DONE at the next edge, so `done` is high one cycle after the final handshake.
- Simultaneous push and pop leave `fifo_level` unchanged.
- Pointers wrap modulo DEPTH.

## Test plan
- Reset, `rec_ready`=1, then commits at pc 0x0000 (REG r3=0x1234) and pc 0x0002 (NOP):
  - Records kind 1 with inum 0, reg 3, val 0x1234, then kind 0 with inum 1, one cycle after each commit.
  - `inst_count` is 2.
- `commit_valid` low for 5 cycles between commits: no records, `inst_count` unchanged, `cycle_count` advances by 5.
- `rec_ready`=0 and 10 NOP commits, DEPTH=8:
  - `fifo_level` is 8, `drop_count` is 2, `inst_count` is 10.
  - Releasing `rec_ready` yields inum 0..7 in order.
- FIFO full and `rec_ready`=0, then commit HALT at pc 0x0010, then 3 more commits:
  - State is HALT_PEND and later commits are ignored; `inst_count` counts only the HALT.
  - Raising `rec_ready` drains 8 records, then kind 5 at pc 0x0010.
  - `done`=1 one cycle after the last pop.
- Commits with `reg_write` & `mem_write` (addr 0x0040, mval 0xBEEF) and with `reg_write` & `mem_read`: kinds 4 and 2 with correct address and value fields.
- `rst` asserted while the FIFO holds 4 entries in DRAIN: next cycle `fifo_level` 0, `rec_valid` 0, `done` 0, counters 0, and new commits are accepted.
